// File: rtl/store_buffer.sv
// Store buffer between the pipeline and a single-port data memory: queues stores,
// drains them in program order when the port is free, and forwards to loads.
module store_buffer #(
    parameter int ADDRESS_LINE = 8,
    parameter int DEPTH        = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    // Store handshake: a store is captured on a rising edge where st_valid && st_ready;
    // while st_ready is low the pipeline holds st_address/st_data and retries.
    input  logic                      st_valid,
    input  logic [ADDRESS_LINE-1:0]   st_address,
    input  logic [7:0]                st_data,
    output logic                      st_ready,
    input  logic                      ld_valid,
    input  logic [ADDRESS_LINE-1:0]   ld_address,
    output logic [7:0]                ld_data,
    output logic                      ld_hit,
    output logic [ADDRESS_LINE-1:0]   mem_address,
    output logic [7:0]                mem_write_data,
    output logic                      mem_write,
    output logic                      mem_read,
    input  logic [7:0]                mem_read_data,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDRESS_LINE-1:0] entry_address [DEPTH];
    logic [7:0]              entry_data    [DEPTH];
    logic [PTR_W-1:0]        head;
    logic [PTR_W-1:0]        tail;
    logic [CNT_W-1:0]        count_q;
    logic                    push;
    logic                    drain;
    logic [PTR_W-1:0]        idx;
    logic                    fwd_hit;
    logic [7:0]              fwd_data;

    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign push     = st_valid && st_ready;
    // Loads own the port; reset also blocks the drain so no stale write escapes.
    assign drain    = !reset && !ld_valid && (count_q != '0);
    assign empty    = (count_q == '0);
    assign count    = count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (drain) head <= head + PTR_W'(1);
            if (push)  tail <= tail + PTR_W'(1);
            case ({push, drain})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage carries no reset; validity comes only from head/count.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            entry_address[tail] <= st_address;
            entry_data[tail]    <= st_data;
        end
    end

    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        if (ld_valid) begin
            mem_read    = 1'b1;
            mem_address = ld_address;
        end else if (drain) begin
            mem_write      = 1'b1;
            mem_address    = entry_address[head];
            mem_write_data = entry_data[head];
        end
    end

    // Walk oldest to youngest so the last match (nearest the tail) wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entry_address[idx] == ld_address)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[idx];
            end
        end
    end

    always_comb begin
        ld_hit  = ld_valid && !reset && fwd_hit;
        ld_data = '0;
        if (ld_valid) ld_data = ld_hit ? fwd_data : mem_read_data;
    end

endmodule
